// File: rtl/riscv_imem_responder.sv
// Instruction-memory responder: request/grant fetch port with one-cycle registered response and a preload port.
// Optional IMEM_RANDOM_STALL_EN adds 0..3 LFSR-driven extra grant wait cycles.
module riscv_imem_responder #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned GNT_WAIT  = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         instr_req_i,
  input  logic [31:0]                  instr_addr_i,
  output logic                         instr_gnt_o,
  output logic                         instr_rvalid_o,
  output logic [31:0]                  instr_rdata_o,
  output logic                         instr_err_o,
  input  logic                         load_we_i,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
  input  logic [31:0]                  load_wdata_i,
  output logic                         busy_o
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
`ifdef IMEM_RANDOM_STALL_EN
  // One extra bit so GNT_WAIT plus up to 3 extra cycles cannot overflow.
  localparam int unsigned CW = 5;
`else
  localparam int unsigned CW = 4;
`endif

  typedef enum logic {IDLE, WAIT_GNT} state_e;

  state_e          state_q;
  logic [CW-1:0]   wait_cnt_q;
  logic [CW-1:0]   tgt_idle;
  logic [CW-1:0]   tgt_wait;
  logic            gnt;
  logic            fault;
  logic [31:0]     off;
  logic [AW-1:0]   idx;
  logic            rvalid_q;
  logic            err_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem_q [MEM_WORDS];

`ifdef IMEM_RANDOM_STALL_EN
  logic [15:0]     lfsr_q;
  logic [CW-1:0]   tgt_q;

  assign tgt_idle = CW'(GNT_WAIT) + CW'(lfsr_q[1:0]);
  assign tgt_wait = tgt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 16'hACE1;
      tgt_q  <= '0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      if (state_q == IDLE) tgt_q <= tgt_idle;
    end
  end
`else
  assign tgt_idle = CW'(GNT_WAIT);
  assign tgt_wait = CW'(GNT_WAIT);
`endif

  // Unsigned subtraction: addresses below the base wrap high and land out of range.
  assign off   = instr_addr_i - BASE_ADDR;
  assign fault = (instr_addr_i[1:0] != 2'b00) ||
                 ({1'b0, off} >= (33'(MEM_WORDS) << 2));
  assign idx   = off[AW+1:2];

  always_comb begin
    gnt = 1'b0;
    if (rst_n && instr_req_i) begin
      case (state_q)
        IDLE:     gnt = (tgt_idle == '0);
        WAIT_GNT: gnt = (wait_cnt_q == tgt_wait);
        default:  gnt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (instr_req_i && (tgt_idle != '0)) begin
            state_q    <= WAIT_GNT;
            wait_cnt_q <= CW'(1);
          end
        end
        WAIT_GNT: begin
          if (!instr_req_i || (wait_cnt_q == tgt_wait)) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  // Response read uses the pre-edge array contents, so a same-cycle preload is not visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt;
      err_q    <= gnt & fault;
      if (gnt) rdata_q <= fault ? '0 : mem_q[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (load_we_i) mem_q[load_addr_i] <= load_wdata_i;
  end

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = rvalid_q;
  assign instr_err_o    = err_q;
  assign instr_rdata_o  = rdata_q;
  assign busy_o         = (state_q == WAIT_GNT) | instr_req_i | rvalid_q;

endmodule

// File: tb/tb_riscv_imem_responder.sv
// Directed bench for riscv_imem_responder: three instances with grant waits 0, 3 and 2.
module tb_riscv_imem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_we;
  logic [3:0]  load_addr;
  logic [31:0] load_wdata;

  logic        req0, gnt0, rv0, err0, busy0;
  logic [31:0] addr0, rd0;
  logic        req3, gnt3, rv3, err3, busy3;
  logic [31:0] addr3, rd3;
  logic        req2, gnt2, rv2, err2, busy2;
  logic [31:0] addr2, rd2;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  riscv_imem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h0), .GNT_WAIT(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req0), .instr_addr_i(addr0),
    .instr_gnt_o(gnt0), .instr_rvalid_o(rv0), .instr_rdata_o(rd0), .instr_err_o(err0),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata), .busy_o(busy0));

  riscv_imem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h0), .GNT_WAIT(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req3), .instr_addr_i(addr3),
    .instr_gnt_o(gnt3), .instr_rvalid_o(rv3), .instr_rdata_o(rd3), .instr_err_o(err3),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata), .busy_o(busy3));

  riscv_imem_responder #(.MEM_WORDS(16), .BASE_ADDR(32'h100), .GNT_WAIT(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .instr_req_i(req2), .instr_addr_i(addr2),
    .instr_gnt_o(gnt2), .instr_rvalid_o(rv2), .instr_rdata_o(rd2), .instr_err_o(err2),
    .load_we_i(load_we), .load_addr_i(load_addr), .load_wdata_i(load_wdata), .busy_o(busy2));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [31:0] data);
    load_we    = 1'b1;
    load_addr  = idx;
    load_wdata = data;
    tick();
    load_we    = 1'b0;
  endtask

  logic [31:0] exp_word [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_word[0] = 32'h0000_0013;
    exp_word[1] = 32'h1111_1111;
    exp_word[2] = 32'h2222_2222;
    exp_word[3] = 32'h3333_3333;

    rst_n = 1'b0; load_we = 1'b0; load_addr = '0; load_wdata = '0;
    req0 = 1'b1; addr0 = '0; req3 = 1'b0; addr3 = '0; req2 = 1'b0; addr2 = '0;

    // Outputs held low in reset, even with a request present.
    #12;
    check_eq("rst_gnt0", {31'b0, gnt0}, 32'd0);
    check_eq("rst_rv0", {31'b0, rv0}, 32'd0);
    check_eq("rst_err0", {31'b0, err0}, 32'd0);
    check_eq("rst_rd0", rd0, 32'd0);
    req0 = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy0", {31'b0, busy0}, 32'd0);
    tick();

    for (int i = 0; i < 4; i++) preload(4'(i), exp_word[i]);
    preload(4'd4, 32'h4444_4444);
    preload(4'd15, 32'hF0F0_F0F0);

    // Single fetch, zero wait.
    req0 = 1'b1; addr0 = 32'h0;
    @(negedge clk);
    check_eq("w0_gnt", {31'b0, gnt0}, 32'd1);
    check_eq("w0_busy", {31'b0, busy0}, 32'd1);
    check_eq("w0_rv_early", {31'b0, rv0}, 32'd0);
    tick(); req0 = 1'b0;
    @(negedge clk);
    check_eq("w0_rv", {31'b0, rv0}, 32'd1);
    check_eq("w0_rd", rd0, 32'h0000_0013);
    check_eq("w0_err", {31'b0, err0}, 32'd0);
    tick();
    @(negedge clk);
    check_eq("w0_rv_pulse", {31'b0, rv0}, 32'd0);
    check_eq("w0_busy_idle", {31'b0, busy0}, 32'd0);
    tick();

    // Back-to-back fetches of words 0..3.
    for (int i = 0; i < 5; i++) begin
      req0  = (i < 4);
      addr0 = 32'(4 * i);
      @(negedge clk);
      check_eq("b2b_gnt", {31'b0, gnt0}, (i < 4) ? 32'd1 : 32'd0);
      if (i > 0) begin
        check_eq("b2b_rv", {31'b0, rv0}, 32'd1);
        check_eq("b2b_rd", rd0, exp_word[i-1]);
      end
      tick();
    end
    req0 = 1'b0;

    // Misaligned, one past the end, and the last valid word.
    for (int i = 0; i < 3; i++) begin
      req0  = 1'b1;
      addr0 = (i == 0) ? 32'h2 : (i == 1) ? 32'h40 : 32'h3C;
      @(negedge clk);
      check_eq("edge_gnt", {31'b0, gnt0}, 32'd1);
      tick(); req0 = 1'b0;
      @(negedge clk);
      check_eq("edge_rv", {31'b0, rv0}, 32'd1);
      check_eq("edge_err", {31'b0, err0}, (i < 2) ? 32'd1 : 32'd0);
      check_eq("edge_rd", rd0, (i < 2) ? 32'd0 : 32'hF0F0_F0F0);
      tick();
    end

    // Grant-cycle preload of the same word returns old contents.
    req0 = 1'b1; addr0 = 32'h10;
    load_we = 1'b1; load_addr = 4'd4; load_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("rbw_gnt", {31'b0, gnt0}, 32'd1);
    tick(); req0 = 1'b0; load_we = 1'b0;
    @(negedge clk);
    check_eq("rbw_old", rd0, 32'h4444_4444);
    tick();
    req0 = 1'b1;
    tick(); req0 = 1'b0;
    @(negedge clk);
    check_eq("rbw_new", rd0, 32'hDEAD_BEEF);
    tick();

    // GNT_WAIT=3: grant on 4th request cycle.
    req3 = 1'b1; addr3 = 32'h8;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("w3_gnt", {31'b0, gnt3}, (i == 3) ? 32'd1 : 32'd0);
      check_eq("w3_busy", {31'b0, busy3}, 32'd1);
      tick();
    end
    req3 = 1'b0;
    @(negedge clk);
    check_eq("w3_rv", {31'b0, rv3}, 32'd1);
    check_eq("w3_rd", rd3, 32'h2222_2222);
    tick();

    // Abort before grant, then a fresh request still needs the full wait.
    req3 = 1'b1; addr3 = 32'h4;
    tick(); tick();
    req3 = 1'b0;
    @(negedge clk);
    check_eq("abort_gnt", {31'b0, gnt3}, 32'd0);
    tick();
    @(negedge clk);
    check_eq("abort_rv", {31'b0, rv3}, 32'd0);
    check_eq("abort_busy", {31'b0, busy3}, 32'd0);
    tick();
    req3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("w3b_gnt", {31'b0, gnt3}, (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    req3 = 1'b0;
    @(negedge clk);
    check_eq("w3b_rd", rd3, 32'h1111_1111);
    tick();

    // Nonzero base: in range, and below base wraps to a fault.
    for (int i = 0; i < 2; i++) begin
      req2  = 1'b1;
      addr2 = (i == 0) ? 32'h104 : 32'hFC;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check_eq("w2_gnt", {31'b0, gnt2}, (c == 2) ? 32'd1 : 32'd0);
        tick();
      end
      req2 = 1'b0;
      @(negedge clk);
      check_eq("w2_rv", {31'b0, rv2}, 32'd1);
      check_eq("w2_err", {31'b0, err2}, (i == 0) ? 32'd0 : 32'd1);
      check_eq("w2_rd", rd2, (i == 0) ? 32'h1111_1111 : 32'd0);
      tick();
    end

    // Reset during WAIT_GNT.
    req2 = 1'b1; addr2 = 32'h104;
    tick();
    @(negedge clk);
    rst_n = 1'b0; req2 = 1'b0;
    #1;
    check_eq("rstw_gnt", {31'b0, gnt2}, 32'd0);
    check_eq("rstw_busy", {31'b0, busy2}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("rstw_after", {30'b0, gnt2, rv2}, 32'd0);
      tick();
    end

    // Reset in the cycle after a grant.
    req2 = 1'b1;
    tick(); tick(); tick();
    req2 = 1'b0; rst_n = 1'b0;
    #1;
    check_eq("rstg_rv", {31'b0, rv2}, 32'd0);
    check_eq("rstg_rd", rd2, 32'd0);
    check_eq("rstg_err", {31'b0, err2}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rstg_after", {30'b0, gnt2, rv2}, 32'd0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_imem_responder.md
RISCV_IMEM_RESPONDER -- requirements
Module: riscv_imem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 4096: number of 32-bit words in the internal instruction array; power of two.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0; MEM_WORDS*4-aligned.
REQ-003 Parameter GNT_WAIT, default 0, range 0..15: fixed cycles of asserted request before grant.
REQ-004 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port instr_req_i, input, 1: fetch request from the instruction-fetch initiator.
REQ-007 Port instr_addr_i, input, 32: fetch byte address; sampled in the grant cycle.
REQ-008 Port instr_gnt_o, output, 1: request accepted this cycle.
REQ-009 Port instr_rvalid_o, output, 1: response valid; one-cycle pulse per grant.
REQ-010 Port instr_rdata_o, output, 32: fetched word; meaningful only with rvalid.
REQ-011 Port instr_err_o, output, 1: access fault, qualified by rvalid; drives the fetch-side PMP error input.
REQ-012 Port load_we_i, input, 1: preload write enable.
REQ-013 Port load_addr_i, input, log2(MEM_WORDS): preload word index.
REQ-014 Port load_wdata_i, input, 32: preload data.
REQ-015 Port busy_o, output, 1: request pending or response outstanding.

Function
REQ-016 FSM states IDLE and WAIT_GNT; wait counter wait_cnt is 4 bits wide.
REQ-017 In IDLE with instr_req_i=1 and GNT_WAIT=0: instr_gnt_o=1 combinationally in the same cycle; the FSM stays in IDLE.
REQ-018 In IDLE with instr_req_i=1 and GNT_WAIT>0: the FSM goes to WAIT_GNT and wait_cnt loads 1.
REQ-019 In WAIT_GNT while instr_req_i=1 and wait_cnt<GNT_WAIT: wait_cnt increments; when wait_cnt==GNT_WAIT, instr_gnt_o=1 and the next state is IDLE with wait_cnt=0.
REQ-020 In WAIT_GNT, if instr_req_i drops (protocol violation, or a branch abort before grant): return to IDLE with wait_cnt=0, no grant, no response.
REQ-021 Response latency is exactly 1: instr_rvalid_o=1 in the cycle after each grant, registered; at most one outstanding transaction.
REQ-022 Back-to-back grants are permitted when GNT_WAIT=0; each produces its own rvalid one cycle later.
REQ-023 Fault condition: instr_addr_i[1:0]!=0, or address outside [BASE_ADDR, BASE_ADDR+MEM_WORDS*4-1]; a fault is still granted.
REQ-024 Faulted response: instr_err_o=1 and instr_rdata_o=32'h0. Normal response: instr_err_o=0 and instr_rdata_o=mem[(addr-BASE_ADDR)>>2].
REQ-025 instr_err_o=0 whenever instr_rvalid_o=0.
REQ-026 Preload port: load_we_i=1 writes load_wdata_i to mem[load_addr_i] at the clock edge; it is independent of FSM state.
REQ-027 Simultaneous grant and preload to the same word: read-before-write; the response returns the old contents.
REQ-028 busy_o = (state==WAIT_GNT) | instr_req_i | instr_rvalid_o.
REQ-029 Address arithmetic uses 32-bit unsigned subtraction; wrap-around below BASE_ADDR counts as out of range.

Reset
REQ-030 On rst_n=0, asynchronously: FSM=IDLE, wait_cnt=0, instr_rvalid_o=0, instr_err_o=0, instr_rdata_o=0; instr_gnt_o=0 while reset is asserted.
REQ-031 Reset mid-transaction discards any pending grant and response; no rvalid appears after reset release for pre-reset requests.
REQ-032 Memory array contents are not reset.

Configuration
REQ-033 Macro IMEM_RANDOM_STALL_EN compiled in: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle; its low 2 bits add 0..3 extra wait cycles to GNT_WAIT, sampled when leaving IDLE. The FSM uses WAIT_GNT even when GNT_WAIT=0 and the sampled extra value is nonzero.
REQ-034 Macro IMEM_RANDOM_STALL_EN absent: no LFSR logic; grant latency is exactly GNT_WAIT.

Verification
REQ-035 Preload mem[0]=32'h0000_0013, GNT_WAIT=0, req addr 32'h0 -> gnt in same cycle; next cycle rvalid=1, rdata=32'h0000_0013, err=0.
REQ-036 GNT_WAIT=3, req held at 32'h8 -> gnt on the 4th cycle of req; rvalid one cycle later with mem[2].
REQ-037 Req at 32'h2 and at BASE_ADDR+MEM_WORDS*4 -> each granted; rvalid with err=1, rdata=0.
REQ-038 GNT_WAIT=0, req held for addresses 0,4,8,12 on consecutive cycles -> 4 grants, 4 rvalids each one cycle later, data in order.
REQ-039 GNT_WAIT=2, rst_n pulsed low during WAIT_GNT, and separately in the cycle after a grant -> no gnt and no rvalid after release; all outputs 0 during reset.
REQ-040 Grant of addr 32'h10 in the same cycle as preload of index 4 with 32'hDEADBEEF -> rvalid returns the old word; a later read returns 32'hDEADBEEF.
